// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state type and default operand width.
package mul_div_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle signed/unsigned multiply (shift-add) and divide (restoring),
// one bit per clock, producing HI/LO with a start/busy/done handshake.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return neg_w(v);
    end else begin
      return v;
    end
  endfunction

  state_t           state;
  state_t           state_next;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] a;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0] b;          // multiplier, then dividend/quotient
  logic [WIDTH:0]   acc;        // upper product half or partial remainder
  logic [WIDTH-1:0] dividend;
  logic [CW-1:0]    cnt;

  logic             op_signed;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             dz;

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (cnt == LAST_CNT) begin
          state_next = FIX;
        end else begin
          state_next = CALC;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-iteration arithmetic and final sign correction
  always_comb begin
    op_signed = ~op[0];
    mul_sum   = acc + {1'b0, a & {WIDTH{b[0]}}};
    div_shift = {acc[WIDTH-1:0], b[WIDTH-1]};
    div_trial = div_shift - {1'b0, a};
    prod_mag  = {acc[WIDTH-1:0], b};
    prod      = neg_res ? neg_2w(prod_mag) : prod_mag;
    quo       = neg_res ? neg_w(b) : b;
    rem       = neg_rem ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    dz        = is_div && (a == {WIDTH{1'b0}});
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      a           <= {WIDTH{1'b0}};
      b           <= {WIDTH{1'b0}};
      acc         <= {(WIDTH+1){1'b0}};
      dividend    <= {WIDTH{1'b0}};
      cnt         <= {CW{1'b0}};
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_res  <= op_signed & (input1[WIDTH-1] ^ input2[WIDTH-1]);
            neg_rem  <= op_signed & op[1] & input1[WIDTH-1];
            dividend <= input1;
            acc      <= {(WIDTH+1){1'b0}};
            cnt      <= {CW{1'b0}};
            if (op[1]) begin
              a <= magnitude(input2, op_signed);
              b <= magnitude(input1, op_signed);
            end else begin
              a <= magnitude(input1, op_signed);
              b <= magnitude(input2, op_signed);
            end
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (!is_div) begin
            {acc, b} <= {mul_sum, b} >> 1;
          end else if (!div_trial[WIDTH]) begin
            acc <= {1'b0, div_trial[WIDTH-1:0]};
            b   <= {b[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {1'b0, div_shift[WIDTH-1:0]};
            b   <= {b[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          if (!is_div) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (dz) begin
            // Divide by zero reports the raw dividend and an all-ones quotient
            hi <= dividend;
            lo <= {WIDTH{1'b1}};
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus hand-written
// handshake, back-to-back and reset sequences, checked via a scoreboard queue.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .input1(input1), .input2(input2), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          start_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[11];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input bit push, input string name);
    exp_t e;
    op = o; input1 = x; input2 = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dbz = edbz; e.start_cyc = cyc; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_done", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
      check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
      check({e.name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
      check({e.name, "_latency"}, 64'(cyc - e.start_cyc), 64'd33);
    end
  endtask

  task automatic wait_result(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        pop_compare();
        got = 1'b1;
      end
    end
    if (!got) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  initial begin
    bit got;
    bit seen;

    tbl[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    tbl[1]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3]  = '{OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0};
    tbl[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[5]  = '{OP_DIVU,  32'd170,      32'd0,        32'd170,      32'hFFFFFFFF, 1'b1};
    tbl[6]  = '{OP_MULTU, 32'd1,        32'd1,        32'h00000000, 32'h00000001, 1'b0};
    tbl[7]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[8]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    tbl[9]  = '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 1'b0};
    tbl[10] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

    reset = 1'b1; start = 1'b0; op = 2'b00; input1 = 32'd0; input2 = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Latency and busy window for the first operation
    issue(OP_MULTU, 32'd255, 32'd170, 32'h0, 32'h0000A956, 1'b0, 1'b1, "multu_255x170");
    for (int i = 0; i <= 33; i++) begin
      @(negedge clk);
      check($sformatf("busy_k%0d", i), {63'd0, busy}, (i < 33) ? 64'd1 : 64'd0);
      if (i == 33) begin
        check("first_done", {63'd0, done}, 64'd1);
        if (done) pop_compare();
        else sb.delete();
      end
    end

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz, 1'b1,
            $sformatf("vec%0d", i));
      wait_result($sformatf("vec%0d", i));
    end

    // Starts while busy are ignored; start in the done cycle is accepted
    @(negedge clk);
    issue(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1, "multu_3x4");
    got = 1'b0;
    for (int j = 0; j < 45 && !got; j++) begin
      @(negedge clk);
      start = (j == 4 || j == 19);
      if (start) begin
        op = OP_DIVU; input1 = 32'd9; input2 = 32'd0;
      end
      if (j == 10) begin
        check("hold_hi", {32'd0, hi}, {32'd0, 32'hFFFFFFFE});
        check("hold_lo", {32'd0, lo}, 64'd2);
        check("hold_busy", {63'd0, busy}, 64'd1);
      end
      if (done) begin
        pop_compare();
        got = 1'b1;
      end
    end
    start = 1'b0;
    if (!got) begin
      check("multu_3x4_timeout", 64'd0, 64'd1);
      sb.delete();
    end
    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, "divu_100_7");
    wait_result("divu_100_7");

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    issue(OP_DIV, 32'd170, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, "div_abort");
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", {63'd0, busy}, 64'd0);
    check("async_done", {63'd0, done}, 64'd0);
    check("async_hi", {32'd0, hi}, 64'd0);
    check("async_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("no_done_after_reset", {63'd0, seen}, 64'd0);
    check("idle_after_reset", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
